load_store_unit: RTL and testbench

//  Multi-cycle memory-access stage for the MIPS core. Consumes the effective address the ALU

---
 rtl/load_store_unit_pkg.sv | 13 +
 rtl/lsu_timeout.sv | 21 ++
 rtl/load_store_unit.sv | 97 +++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: opcodes, FSM state encoding and decode helper for the load/store unit
package load_store_unit_pkg;

    localparam logic [5:0] OPCODE_LW = 6'h23;
    localparam logic [5:0] OPCODE_SW = 6'h2b;

    typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;

    function automatic logic is_mem(input logic [5:0] op);
        return op == OPCODE_LW || op == OPCODE_SW;
    endfunction

endpackage

// File: rtl/lsu_timeout.sv
// lsu_timeout: load-clear cycle counter that flags expiry at TIMEOUT-1
module lsu_timeout #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    assign expired = cnt == CNT_W'(TIMEOUT - 1);

    // count while enabled, otherwise hold at zero so every request starts fresh
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= en ? cnt + 1'b1 : '0;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle LW/SW stage driving a req/ack word bus with timeout and misalign detection
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rt,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);

    lsu_state_t state;
    logic [4:0] rt_q;
    logic       expired;

    assign busy = state == REQ;

    lsu_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .en      (state == REQ),
        .expired (expired)
    );

    // access FSM; RESP accepts a new start exactly like IDLE for back-to-back accesses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rt_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            wb_en    <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                REQ: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        wb_en   <= ~mem_we;
                        wb_reg  <= rt_q;
                        wb_data <= mem_rdata;
                    end else if (expired) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (start && is_mem(opcode)) begin
                        if (addr[1:0] == 2'b00) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= opcode == OPCODE_SW;
                            mem_addr  <= addr;
                            mem_wdata <= wdata;
                            rt_q      <= rt;
                        end else begin
                            misalign <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rt = '0;
    logic        busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        done, wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misalign, bus_err;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, ADDI = 6'h08;

    load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .rt        (rt),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .done      (done),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .misalign  (misalign),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_req"}, {31'd0, mem_req}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_wb_en"}, {31'd0, wb_en}, 0);
        chk({tag, "_misalign"}, {31'd0, misalign}, 0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 0);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        start = 1'b1; opcode = op; addr = a; wdata = d; rt = r;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        quiet("reset");
        chk("reset_addr", mem_addr, 0);
        chk("reset_wb_data", wb_data, 0);
        reset = 1'b0;

        // non-memory opcode and stray ack are ignored
        issue(ADDI, 32'h100, 32'h0, 5'd1);
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1;
        quiet("addi");
        @(negedge clk);
        mem_ack = 1'b0;
        quiet("idle_ack");
        chk("idle_ack_addr", mem_addr, 0);

        // LW with ack on third request cycle
        issue(LW, 32'h100, 32'h0, 5'd8);
        mem_rdata = 32'hdeadbeef;
        @(negedge clk);
        start = 1'b0;
        chk("lw_req1", {31'd0, mem_req}, 1);
        chk("lw_busy", {31'd0, busy}, 1);
        chk("lw_we", {31'd0, mem_we}, 0);
        chk("lw_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("lw_req2", {31'd0, mem_req}, 1);
        @(negedge clk);
        chk("lw_req3", {31'd0, mem_req}, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lw_done", {31'd0, done}, 1);
        chk("lw_wb_en", {31'd0, wb_en}, 1);
        chk("lw_wb_reg", {27'd0, wb_reg}, 8);
        chk("lw_wb_data", wb_data, 32'hdeadbeef);
        chk("lw_req_off", {31'd0, mem_req}, 0);
        chk("lw_busy_off", {31'd0, busy}, 0);
        @(negedge clk);
        quiet("lw_after");

        // SW acked on first request cycle
        issue(SW, 32'h204, 32'h12345678, 5'd0);
        @(negedge clk);
        start = 1'b0;
        chk("sw_req", {31'd0, mem_req}, 1);
        chk("sw_we", {31'd0, mem_we}, 1);
        chk("sw_addr", mem_addr, 32'h204);
        chk("sw_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("sw_done", {31'd0, done}, 1);
        chk("sw_wb_en", {31'd0, wb_en}, 0);
        @(negedge clk);
        quiet("sw_after");

        // misaligned LW
        issue(LW, 32'h102, 32'h0, 5'd4);
        @(negedge clk);
        start = 1'b0;
        chk("mis_pulse", {31'd0, misalign}, 1);
        chk("mis_req", {31'd0, mem_req}, 0);
        chk("mis_busy", {31'd0, busy}, 0);
        @(negedge clk);
        quiet("mis_after");

        // LW with no ack: exactly 16 request cycles then bus error
        issue(LW, 32'h300, 32'h0, 5'd5);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_req%0d", i), {31'd0, mem_req}, 1);
            chk($sformatf("to_err%0d", i), {31'd0, bus_err}, 0);
            @(negedge clk);
        end
        chk("to_bus_err", {31'd0, bus_err}, 1);
        chk("to_req_off", {31'd0, mem_req}, 0);
        chk("to_busy_off", {31'd0, busy}, 0);
        chk("to_done", {31'd0, done}, 0);
        @(negedge clk);
        quiet("to_after");

        // back-to-back: SW accepted during the LW response cycle
        issue(LW, 32'h400, 32'h0, 5'd3);
        mem_rdata = 32'hcafef00d;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1;
        chk("b2b_req", {31'd0, mem_req}, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_done", {31'd0, done}, 1);
        chk("b2b_wb_reg", {27'd0, wb_reg}, 3);
        chk("b2b_wb_data", wb_data, 32'hcafef00d);
        issue(SW, 32'h408, 32'h55, 5'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_req2", {31'd0, mem_req}, 1);
        chk("b2b_we2", {31'd0, mem_we}, 1);
        chk("b2b_addr2", mem_addr, 32'h408);
        chk("b2b_done_off", {31'd0, done}, 0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_done2", {31'd0, done}, 1);
        chk("b2b_wb_en2", {31'd0, wb_en}, 0);

        // reset mid-request drops the bus asynchronously
        @(negedge clk);
        issue(LW, 32'h500, 32'h0, 5'd7);
        @(negedge clk);
        start = 1'b0;
        chk("rst_req_before", {31'd0, mem_req}, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_req_async", {31'd0, mem_req}, 0);
        chk("rst_busy_async", {31'd0, busy}, 0);
        @(negedge clk);
        quiet("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        quiet("rst_after");

        // normal LW after reset
        issue(LW, 32'h600, 32'h0, 5'd9);
        mem_rdata = 32'h0badf00d;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1;
        chk("post_req", {31'd0, mem_req}, 1);
        chk("post_addr", mem_addr, 32'h600);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post_done", {31'd0, done}, 1);
        chk("post_wb_en", {31'd0, wb_en}, 1);
        chk("post_wb_reg", {27'd0, wb_reg}, 9);
        chk("post_wb_data", wb_data, 32'h0badf00d);
        @(negedge clk);
        quiet("post_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
